// File: rtl/ramb4_s16_port_arb.sv
// ramb4_s16_port_arb
// Round-robin arbiter giving two requesters shared access to one port of a
// 256x16 synchronous block RAM. Read data (one cycle latency) is steered back
// to whichever requester issued the read.
//
// Optional feature: define RAMB4_S16_PORT_ARB_INIT_CLEAR_EN to add a CLEAR
// sequence after reset that writes INIT_VALUE to every RAM location before
// arbitration starts. BUSY is high while that sequence runs.
module ramb4_s16_port_arb #(
    parameter int                 ADDR_W     = 8,
    parameter int                 DATA_W     = 16,
    parameter logic [DATA_W-1:0]  INIT_VALUE = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              REQ0,
    input  logic              WE0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [DATA_W-1:0] DI0,
    output logic              GNT0,
    output logic              RVLD0,
    output logic [DATA_W-1:0] DO0,

    input  logic              REQ1,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] DI1,
    output logic              GNT1,
    output logic              RVLD1,
    output logic [DATA_W-1:0] DO1,

    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO,

    output logic              BUSY
);

    // Arbitration is allowed only in RUN and never while reset is held, so
    // that GNT and RAM_EN read as 0 during reset even if requests are high.
    logic              w_runActive;
    // High in cycles where the clear sequence owns the RAM port.
    logic              w_clearActive;
    // Address written by the clear sequence in the current cycle.
    logic [ADDR_W-1:0] w_clearAddr;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grantIsRead;

    // Id of the most recently granted requester; the other one wins a tie.
    logic              r_last;

    // Tag of the read in flight: captured at the grant edge, consumed the
    // following cycle when RAM_DO carries the data.
    logic              r_tagValid;
    logic              r_tagId;

    // Last delivered read word per requester, shown on DOx between reads.
    logic [DATA_W-1:0] r_do0Hold;
    logic [DATA_W-1:0] r_do1Hold;

`ifdef RAMB4_S16_PORT_ARB_INIT_CLEAR_EN

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clrCnt;

    // State register; reset parks the FSM in CLEAR so the sweep restarts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Leave CLEAR once the final address has been written this cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clrCnt == {ADDR_W{1'b1}}) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                w_nextState = ST_RUN;
            end
            default: begin
                w_nextState = ST_CLEAR;
            end
        endcase
    end

    // Sweep counter: one address per cycle while clearing, restarts on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_clrCnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clrCnt <= r_clrCnt + 1'b1;
        end
    end

    assign w_clearActive = (r_state == ST_CLEAR) && !RST;
    assign w_runActive   = (r_state == ST_RUN) && !RST;
    assign w_clearAddr   = r_clrCnt;
    assign BUSY          = (r_state == ST_CLEAR);

`else

    assign w_clearActive = 1'b0;
    assign w_runActive   = !RST;
    assign w_clearAddr   = '0;
    assign BUSY          = 1'b0;

`endif

    // Round-robin grant: a lone requester always wins, a tie goes to the
    // requester that was not granted last.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_runActive) begin
            if (REQ0 && REQ1) begin
                if (r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else if (REQ0) begin
                w_gnt0 = 1'b1;
            end else if (REQ1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign GNT0 = w_gnt0;
    assign GNT1 = w_gnt1;

    assign w_grantIsRead = (w_gnt0 && !WE0) || (w_gnt1 && !WE1);

    // RAM port mux: clear sweep, then granted requester; idle drives zeros.
    always_comb begin
        RAM_EN   = 1'b0;
        RAM_WE   = 1'b0;
        RAM_ADDR = '0;
        RAM_DI   = '0;
        if (w_clearActive) begin
            RAM_EN   = 1'b1;
            RAM_WE   = 1'b1;
            RAM_ADDR = w_clearAddr;
            RAM_DI   = INIT_VALUE;
        end else if (w_gnt0) begin
            RAM_EN   = 1'b1;
            RAM_WE   = WE0;
            RAM_ADDR = ADDR0;
            RAM_DI   = WE0 ? DI0 : '0;
        end else if (w_gnt1) begin
            RAM_EN   = 1'b1;
            RAM_WE   = WE1;
            RAM_ADDR = ADDR1;
            RAM_DI   = WE1 ? DI1 : '0;
        end
    end

    // Remember who was served last; an idle cycle leaves the pointer alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end

    // Tag the read issued this cycle; reset discards any read in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tagValid <= 1'b0;
            r_tagId    <= 1'b0;
        end else begin
            r_tagValid <= w_grantIsRead;
            r_tagId    <= w_gnt1;
        end
    end

    assign RVLD0 = r_tagValid && !r_tagId;
    assign RVLD1 = r_tagValid &&  r_tagId;

    // Keep the most recent read word so DOx is stable between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_do0Hold <= '0;
            r_do1Hold <= '0;
        end else begin
            if (RVLD0) begin
                r_do0Hold <= RAM_DO;
            end
            if (RVLD1) begin
                r_do1Hold <= RAM_DO;
            end
        end
    end

    // RAM_DO is already valid in the response cycle, so pass it straight
    // through rather than adding another cycle of latency.
    assign DO0 = RVLD0 ? RAM_DO : r_do0Hold;
    assign DO1 = RVLD1 ? RAM_DO : r_do1Hold;

endmodule

// File: doc/ramb4_s16_port_arb.md
Name: ramb4_s16_port_arb

Overview:
- Two-requester round-robin arbiter that shares one port of a 256x16 synchronous block RAM (RAMB4_S16-class port).
- Grants at most one access per cycle and drives the RAM port's EN/WE/ADDR/DI.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between two client engines and a single RAM port; the RAM's other port stays free for another agent.

Parameters:
- ADDR_W, 8, RAM address width (256 words).
- DATA_W, 16, RAM data width.
- INIT_VALUE, 16'h0000, word written to every location by the optional clear sequence.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0  in  1  requester 0 access request, level.
- WE0  in  1  requester 0 write (1) / read (0).
- ADDR0  in  ADDR_W  requester 0 address.
- DI0  in  DATA_W  requester 0 write data.
- GNT0  out  1  requester 0 access accepted this cycle.
- RVLD0  out  1  DO0 holds requester 0 read data.
- DO0  out  DATA_W  requester 0 read data.
- REQ1, WE1, ADDR1, DI1, GNT1, RVLD1, DO1: same as the requester 0 ports, for requester 1.
- RAM_EN  out  1  RAM port enable.
- RAM_WE  out  1  RAM port write enable.
- RAM_ADDR  out  ADDR_W  RAM port address.
- RAM_DI  out  DATA_W  RAM port write data.
- RAM_DO  in  DATA_W  RAM port read data, valid the cycle after RAM_EN.
- BUSY  out  1  controller unavailable (clear sequence running).

Behaviour:
- Reset values while RST=1: GNT0/1=0, RVLD0/1=0, DO0/1=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, RAM_DI=0, BUSY=0 (1 if the optional feature is compiled in). LAST pointer=1.
- States:
  - CLEAR: present only with the optional feature.
  - RUN: normal arbitration.
- Grant decision in RUN is combinational in cycle N from REQ0/REQ1/LAST:
  - Only REQx high: grant x.
  - Both high: grant the requester != LAST.
  - Neither high: no grant, RAM_EN=0.
- Granted requester's WE/ADDR/DI drive RAM_WE/RAM_ADDR/RAM_DI in cycle N with RAM_EN=1, and GNTx=1 in cycle N.
- Requester treats GNTx=1 at the clock edge as the transfer completing; it may change ADDR/DI or drop REQ next cycle.
- LAST updates to x at the edge ending a cycle that granted x. It holds when there is no grant.
- Read completion:
  - A read granted in cycle N asserts RVLDx in cycle N+1 for exactly 1 cycle, with DOx=RAM_DO.
  - DOx holds its last value otherwise.
  - Writes never assert RVLD.
  - Back-to-back reads give RVLD on consecutive cycles.
  - Tag register (valid bit + requester id) is captured at the grant edge.
- Continuous requests from both requesters alternate strictly 0,1,0,1... A single requester holding REQ is granted every cycle; throughput is 1 access/cycle.
- RAM_ADDR/RAM_DI may carry don't-care values when RAM_EN=0; the implementation drives 0 on them.
- RST asserted mid-read: the pending RVLD is dropped and never emitted after reset release.
- No reordering: response order equals grant order.
- Both requesters reading and writing the same address in consecutive cycles behaves as the RAM's in-order port semantics. The arbiter adds no hazard logic.

Optional Feature:
- Macro: RAMB4_S16_PORT_ARB_INIT_CLEAR_EN.
- With the macro defined:
  - After RST deasserts, the FSM enters CLEAR.
  - An ADDR_W-bit counter starts at 0. Each cycle drives RAM_EN=1, RAM_WE=1, RAM_ADDR=count, RAM_DI=INIT_VALUE.
  - GNT0/1=0 and BUSY=1 throughout.
  - After address 255 is written (256 cycles), the FSM enters RUN and BUSY=0.
  - RST during CLEAR restarts the count from 0.
- Without the macro: no CLEAR state, no counter, BUSY tied 0; RUN is entered on the first edge after RST deasserts.

Test Plan:
- Single write/read: REQ0=1, WE0=1, ADDR0=8'h12, DI0=16'hA5C3 one cycle, then a read of 8'h12 with RAM model -> GNT0 both cycles; RVLD0=1 the cycle after the read grant with DO0=16'hA5C3; RVLD1 stays 0.
- Contention: REQ0 and REQ1 both held high for 6 cycles after reset -> grants 0,1,0,1,0,1. With both reading addresses 8'h00/8'hFF, RVLD alternates 0,1 with the matching data.
- Idle gap fairness: requester 1 alone granted at cycle 0, idle at cycle 1, both request at cycle 2 -> GNT0 at cycle 2.
- Reset mid-read: read granted, RST pulsed asynchronously before the next edge -> RVLD0/1 never assert after release; GNT0/1=0 and RAM_EN=0 while RST=1.
- Back-to-back reads from one requester: REQ1 read of addresses 1,2,3 on consecutive cycles -> RVLD1 high 3 consecutive cycles with data of 1,2,3 in order.
- With the macro defined: release RST, hold REQ0=1 -> BUSY=1 and RAM_WE=1 for exactly 256 cycles covering addresses 0..255 with 16'h0000, no GNT0. First GNT0 on cycle 256; a read of any address returns 16'h0000.
